seq_divider: RTL and testbench

- Sequential restoring unsigned divider. It is the inverse counterpart of the team's combinational array multiplier.
- Takes a WIDTH-bit dividend and divisor and produces quotient and remainder, one quotient bit per clock.
- Uses a start/done handshake, so it can sit behind a register-file or ALU controller in the lab datapath.
- Satisfies Q*B + R == A for every non-zero divisor.

---
 rtl/seq_divider.sv | 124 ++++++++++++
 tb/tb_seq_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Start/done handshake; divide-by-zero returns all-ones quotient and R=A.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] qsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   sub_d;
  logic             ge_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] qsr_d;
  logic             accept;
  logic             last;

  // The restored remainder is always below B, so WIDTH bits hold it;
  // the shifted value and the trial subtraction need the extra bit.
  always_comb begin
    shift_d = {rem_q, qsr_q[WIDTH-1]};
    sub_d   = shift_d - {1'b0, b_q};
    ge_d    = ~sub_d[WIDTH];
    rem_d   = ge_d ? sub_d[WIDTH-1:0]
                   : shift_d[WIDTH-1:0];
    qsr_d   = {qsr_q[WIDTH-2:0], ge_d};
  end

  assign accept = start && (state_q != CALC);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      qsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (accept) begin
            b_q <= B;
            if (B == '0) begin
              q_q     <= '1;
              r_q     <= A;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rem_q   <= '0;
              qsr_q   <= A;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          qsr_q <= qsr_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            q_q     <= qsr_d;
            r_q     <= rem_d;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model plus directed,
// random and exhaustive back-to-back stimulus.
module tb_seq_divider;
  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         dz;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(A),
    .B(B),
    .Q(Q),
    .R(R),
    .busy(busy),
    .done(done),
    .div_by_zero(dz)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit sweep_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: result = A/B, A%B, ready WIDTH edges after acceptance.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_acc  = 1'b0;
  logic         m_dz   = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic [W-1:0] p_q = '0, p_r = '0;
  logic [W-1:0] m_a = '0, m_b = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_acc  <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else begin
      m_acc  <= 1'b0;
      m_done <= 1'b0;
      if (start && m_left == 0) begin
        m_acc <= 1'b1;
        m_a   <= A;
        m_b   <= B;
        if (B == 0) begin
          m_q    <= '1;
          m_r    <= A;
          m_dz   <= 1'b1;
          m_done <= 1'b1;
        end else begin
          p_q    <= A / B;
          p_r    <= A % B;
          m_left <= W;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_q    <= p_q;
          m_r    <= p_r;
          m_dz   <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_left > 0));
    chk("done", int'(done), int'(m_done));
    chk("Q", int'(Q), int'(m_q));
    chk("R", int'(R), int'(m_r));
    chk("div_by_zero", int'(dz), int'(m_dz));
    if (done && rst_n) begin
      if (sweep_on) done_cnt++;
      if (!dz) begin
        chk("QB_plus_R", int'(Q) * int'(m_b) + int'(R), int'(m_a));
        chk("R_lt_B", int'(R < m_b), 1);
      end else begin
        chk("dz_B_zero", int'(m_b), 0);
      end
    end
  end

  task automatic run_op(input string nm, input int a, input int b,
                        input int eq, input int er, input int edz,
                        input int elat);
    int lat;
    int nb;
    A     = W'(a);
    B     = W'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nb    = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_cycles"}, nb, elat - 1);
    chk({nm, "_Q"}, int'(Q), eq);
    chk({nm, "_R"}, int'(R), er);
    chk({nm, "_dz"}, int'(dz), edz);
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int i;
    i = 0;
    while (!done && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_done_seen"}, int'(done), 1);
  endtask

  initial begin
    int idx;
    int guard;
    repeat (2) @(negedge clk);
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dz", int'(dz), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("d13_3", 13, 3, 4, 1, 0, W + 1);
    run_op("d15_1", 15, 1, 15, 0, 0, W + 1);
    run_op("d7_9", 7, 9, 0, 7, 0, W + 1);
    run_op("d15_15", 15, 15, 1, 0, 0, W + 1);
    run_op("d14_8", 14, 8, 1, 6, 0, W + 1);
    run_op("d9_0", 9, 0, 15, 9, 1, 1);
    run_op("d8_2", 8, 2, 4, 0, 0, W + 1);
    run_op("d0_5", 0, 5, 0, 0, 0, W + 1);

    A     = 13;
    B     = 3;
    start = 1'b1;
    @(negedge clk);
    A = 1;
    B = 1;
    @(negedge clk);
    A = 0;
    B = 7;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    chk("ign_Q", int'(Q), 4);
    chk("ign_R", int'(R), 1);
    A     = 8;
    B     = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    wait_done("b2b");
    chk("b2b_Q", int'(Q), 4);
    chk("b2b_R", int'(R), 0);
    @(negedge clk);

    A     = 13;
    B     = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_Q", int'(Q), 0);
    chk("arst_R", int'(R), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("d6_4", 6, 4, 1, 2, 0, W + 1);

    for (int i = 0; i < 400; i++) begin
      start = 1'($urandom_range(0, 1));
      A     = W'($urandom);
      B     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    done_cnt = 0;
    sweep_on = 1'b1;
    idx      = 0;
    guard    = 0;
    A        = 0;
    B        = 0;
    start    = 1'b1;
    while (idx < 256 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (m_acc) begin
        idx++;
        if (idx < 256) begin
          A = W'(idx >> 4);
          B = W'(idx & 15);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    sweep_on = 1'b0;
    chk("sweep_accepted", idx, 256);
    chk("sweep_done_count", done_cnt, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
